// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Decodes RV64I (optionally RV32I when XLEN=32) plus optional Zba from the
//   D-stage instruction and carries the control bundle through the E, M and W
//   pipeline registers. Illegal encodings produce an all-zero bundle with only
//   the illegal bit set. A counter tracks instructions retiring from W.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   InstrD                instruction in the D stage
//   FlushE                turns the instruction entering E into a bubble
//   ImmSrcD, IllegalD     combinational D-stage decode outputs
//   *E / *M / *W          per-stage control outputs
//   IllegalW              illegal instruction has reached W
//   InstretW              retired-instruction count (wraps)
module pipelined_control_unit #(
  parameter int XLEN   = 64,
  parameter int ZBA_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrD,
  input  logic             FlushE,
  output logic [2:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             RegWriteE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ResultSrcM,
  output logic [1:0]       ResultSrcW,
  output logic             MemWriteE,
  output logic             MemWriteM,
  output logic [2:0]       MemSizeE,
  output logic [2:0]       MemSizeM,
  output logic [3:0]       ALUControlE,
  output logic             ALUSrcAE,
  output logic             ALUSrcBE,
  output logic             WordOpE,
  output logic             UwOpE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             JalrE,
  output logic [2:0]       BranchFunctE,
  output logic             IllegalW,
  output logic [CNT_W-1:0] InstretW
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit ZBA  = (ZBA_EN != 0);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_SH1ADD = 4'b0100;
  localparam logic [3:0] ALU_SH2ADD = 4'b0101;
  localparam logic [3:0] ALU_SH3ADD = 4'b0110;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_SLL    = 4'b1010;
  localparam logic [3:0] ALU_SRL    = 4'b1011;
  localparam logic [3:0] ALU_SRA    = 4'b1100;

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] mem_size;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       word_op;
    logic       uw_op;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] branch_funct;
  } e_bundle_t;

  // Later stages only keep the fields they still drive.
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] mem_size;
  } m_bundle_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
  } w_bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  e_bundle_t  dec_next;
  e_bundle_t  e_reg;
  m_bundle_t  m_reg;
  w_bundle_t  w_reg;
  logic [CNT_W-1:0] instret_reg;

  // Register specifiers are consumed by the datapath, not by this decoder.
  logic unused_fields;
  assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  always_comb begin
    ImmSrcD = 3'b000;
    case (opcode)
      OPC_STORE:            ImmSrcD = 3'b001;
      OPC_BRANCH:           ImmSrcD = 3'b010;
      OPC_JAL:              ImmSrcD = 3'b011;
      OPC_LUI, OPC_AUIPC:   ImmSrcD = 3'b100;
      default:              ImmSrcD = 3'b000;
    endcase
  end

  always_comb begin
    dec_next = '0;
    legal    = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        legal               = (funct3 != 3'b111) && (RV64 || funct3 != 3'b011);
        dec_next.reg_write  = 1'b1;
        dec_next.result_src = RES_MEM;
        dec_next.alu_src_b  = 1'b1;
        dec_next.mem_size   = funct3;
      end
      OPC_STORE: begin
        legal              = !funct3[2] && (RV64 || funct3 != 3'b011);
        dec_next.mem_write = 1'b1;
        dec_next.alu_src_b = 1'b1;
        dec_next.mem_size  = funct3;
      end
      OPC_OP_IMM: begin
        legal              = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src_b = 1'b1;
        case (funct3)
          3'b000: dec_next.alu_control = ALU_ADD;
          3'b010: dec_next.alu_control = ALU_SLT;
          3'b011: dec_next.alu_control = ALU_SLTU;
          3'b100: dec_next.alu_control = ALU_XOR;
          3'b110: dec_next.alu_control = ALU_OR;
          3'b111: dec_next.alu_control = ALU_AND;
          3'b001: begin
            dec_next.alu_control = ALU_SLL;
            legal = (InstrD[31:26] == 6'b000000);
          end
          default: begin
            dec_next.alu_control = InstrD[30] ? ALU_SRA : ALU_SRL;
            legal = (InstrD[31:26] == 6'b000000) || (InstrD[31:26] == 6'b010000);
          end
        endcase
      end
      OPC_OP: begin
        dec_next.reg_write = 1'b1;
        case (funct7)
          7'b0000000: begin
            legal = 1'b1;
            case (funct3)
              3'b000:  dec_next.alu_control = ALU_ADD;
              3'b001:  dec_next.alu_control = ALU_SLL;
              3'b010:  dec_next.alu_control = ALU_SLT;
              3'b011:  dec_next.alu_control = ALU_SLTU;
              3'b100:  dec_next.alu_control = ALU_XOR;
              3'b101:  dec_next.alu_control = ALU_SRL;
              3'b110:  dec_next.alu_control = ALU_OR;
              default: dec_next.alu_control = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              legal = 1'b1;
              dec_next.alu_control = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              legal = 1'b1;
              dec_next.alu_control = ALU_SRA;
            end
          end
          7'b0010000: begin
            if (ZBA) begin
              case (funct3)
                3'b010: begin legal = 1'b1; dec_next.alu_control = ALU_SH1ADD; end
                3'b100: begin legal = 1'b1; dec_next.alu_control = ALU_SH2ADD; end
                3'b110: begin legal = 1'b1; dec_next.alu_control = ALU_SH3ADD; end
                default: legal = 1'b0;
              endcase
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        dec_next.reg_write = 1'b1;
        if (RV64) begin
          case (funct7)
            7'b0000000: begin
              dec_next.word_op = 1'b1;
              case (funct3)
                3'b000: begin legal = 1'b1; dec_next.alu_control = ALU_ADD; end
                3'b001: begin legal = 1'b1; dec_next.alu_control = ALU_SLL; end
                3'b101: begin legal = 1'b1; dec_next.alu_control = ALU_SRL; end
                default: legal = 1'b0;
              endcase
            end
            7'b0100000: begin
              dec_next.word_op = 1'b1;
              case (funct3)
                3'b000: begin legal = 1'b1; dec_next.alu_control = ALU_SUB; end
                3'b101: begin legal = 1'b1; dec_next.alu_control = ALU_SRA; end
                default: legal = 1'b0;
              endcase
            end
            // add.uw: full-width add of zero-extended rs1, so not a word op.
            7'b0000100: begin
              dec_next.uw_op = 1'b1;
              legal = ZBA && (funct3 == 3'b000);
            end
            7'b0010000: begin
              dec_next.uw_op = 1'b1;
              if (ZBA) begin
                case (funct3)
                  3'b010: begin legal = 1'b1; dec_next.alu_control = ALU_SH1ADD; end
                  3'b100: begin legal = 1'b1; dec_next.alu_control = ALU_SH2ADD; end
                  3'b110: begin legal = 1'b1; dec_next.alu_control = ALU_SH3ADD; end
                  default: legal = 1'b0;
                endcase
              end
            end
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM_32: begin
        dec_next.reg_write = 1'b1;
        dec_next.alu_src_b = 1'b1;
        dec_next.word_op   = 1'b1;
        if (RV64) begin
          case (funct3)
            3'b000: legal = 1'b1;
            3'b001: begin
              legal = (funct7 == 7'b0000000);
              dec_next.alu_control = ALU_SLL;
            end
            3'b101: begin
              legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
              dec_next.alu_control = InstrD[30] ? ALU_SRA : ALU_SRL;
            end
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_BRANCH: begin
        // Comparison is resolved in the datapath from BranchFunctE.
        legal                 = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec_next.branch       = 1'b1;
        dec_next.alu_control  = ALU_SUB;
        dec_next.branch_funct = funct3;
      end
      OPC_JAL: begin
        legal               = 1'b1;
        dec_next.reg_write  = 1'b1;
        dec_next.result_src = RES_PC4;
        dec_next.jump       = 1'b1;
      end
      OPC_JALR: begin
        legal               = 1'b1;
        dec_next.reg_write  = 1'b1;
        dec_next.result_src = RES_PC4;
        dec_next.alu_src_b  = 1'b1;
        dec_next.jalr       = 1'b1;
      end
      OPC_LUI: begin
        legal               = 1'b1;
        dec_next.reg_write  = 1'b1;
        dec_next.result_src = RES_IMM;
      end
      OPC_AUIPC: begin
        legal              = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src_a = 1'b1;
        dec_next.alu_src_b = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings must not leak any side effect downstream.
    if (!legal) begin
      dec_next         = '0;
      dec_next.illegal = 1'b1;
    end else begin
      dec_next.valid = 1'b1;
    end
  end

  assign IllegalD = dec_next.illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg       <= '0;
      m_reg       <= '0;
      w_reg       <= '0;
      instret_reg <= '0;
    end else begin
      e_reg <= FlushE ? '0 : dec_next;

      m_reg.valid      <= e_reg.valid;
      m_reg.illegal    <= e_reg.illegal;
      m_reg.reg_write  <= e_reg.reg_write;
      m_reg.result_src <= e_reg.result_src;
      m_reg.mem_write  <= e_reg.mem_write;
      m_reg.mem_size   <= e_reg.mem_size;

      w_reg.valid      <= m_reg.valid;
      w_reg.illegal    <= m_reg.illegal;
      w_reg.reg_write  <= m_reg.reg_write;
      w_reg.result_src <= m_reg.result_src;

      if (w_reg.valid && !w_reg.illegal) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  assign RegWriteE    = e_reg.reg_write;
  assign ResultSrcE   = e_reg.result_src;
  assign MemWriteE    = e_reg.mem_write;
  assign MemSizeE     = e_reg.mem_size;
  assign ALUControlE  = e_reg.alu_control;
  assign ALUSrcAE     = e_reg.alu_src_a;
  assign ALUSrcBE     = e_reg.alu_src_b;
  assign WordOpE      = e_reg.word_op;
  assign UwOpE        = e_reg.uw_op;
  assign BranchE      = e_reg.branch;
  assign JumpE        = e_reg.jump;
  assign JalrE        = e_reg.jalr;
  assign BranchFunctE = e_reg.branch_funct;

  assign RegWriteM    = m_reg.reg_write;
  assign ResultSrcM   = m_reg.result_src;
  assign MemWriteM    = m_reg.mem_write;
  assign MemSizeM     = m_reg.mem_size;

  assign RegWriteW    = w_reg.reg_write;
  assign ResultSrcW   = w_reg.result_src;
  assign IllegalW     = w_reg.illegal;
  assign InstretW     = instret_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit. Two instances share the inputs:
//   a: XLEN=64, ZBA_EN=1, CNT_W=32
//   b: XLEN=32, ZBA_EN=0, CNT_W=4
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = 32'h0;
  logic        FlushE = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] ImmSrcD_a, ImmSrcD_b;
  logic       IllegalD_a, IllegalD_b;
  logic       RegWriteE_a, RegWriteM_a, RegWriteW_a, RegWriteE_b, RegWriteM_b, RegWriteW_b;
  logic [1:0] ResultSrcE_a, ResultSrcM_a, ResultSrcW_a, ResultSrcE_b, ResultSrcM_b, ResultSrcW_b;
  logic       MemWriteE_a, MemWriteM_a, MemWriteE_b, MemWriteM_b;
  logic [2:0] MemSizeE_a, MemSizeM_a, MemSizeE_b, MemSizeM_b;
  logic [3:0] ALUControlE_a, ALUControlE_b;
  logic       ALUSrcAE_a, ALUSrcBE_a, WordOpE_a, UwOpE_a, BranchE_a, JumpE_a, JalrE_a;
  logic       ALUSrcAE_b, ALUSrcBE_b, WordOpE_b, UwOpE_b, BranchE_b, JumpE_b, JalrE_b;
  logic [2:0] BranchFunctE_a, BranchFunctE_b;
  logic       IllegalW_a, IllegalW_b;
  logic [31:0] InstretW_a;
  logic [3:0]  InstretW_b;

  pipelined_control_unit #(.XLEN(64), .ZBA_EN(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD_a), .IllegalD(IllegalD_a),
    .RegWriteE(RegWriteE_a), .RegWriteM(RegWriteM_a), .RegWriteW(RegWriteW_a),
    .ResultSrcE(ResultSrcE_a), .ResultSrcM(ResultSrcM_a), .ResultSrcW(ResultSrcW_a),
    .MemWriteE(MemWriteE_a), .MemWriteM(MemWriteM_a),
    .MemSizeE(MemSizeE_a), .MemSizeM(MemSizeM_a),
    .ALUControlE(ALUControlE_a), .ALUSrcAE(ALUSrcAE_a), .ALUSrcBE(ALUSrcBE_a),
    .WordOpE(WordOpE_a), .UwOpE(UwOpE_a), .BranchE(BranchE_a), .JumpE(JumpE_a),
    .JalrE(JalrE_a), .BranchFunctE(BranchFunctE_a), .IllegalW(IllegalW_a),
    .InstretW(InstretW_a)
  );

  pipelined_control_unit #(.XLEN(32), .ZBA_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD_b), .IllegalD(IllegalD_b),
    .RegWriteE(RegWriteE_b), .RegWriteM(RegWriteM_b), .RegWriteW(RegWriteW_b),
    .ResultSrcE(ResultSrcE_b), .ResultSrcM(ResultSrcM_b), .ResultSrcW(ResultSrcW_b),
    .MemWriteE(MemWriteE_b), .MemWriteM(MemWriteM_b),
    .MemSizeE(MemSizeE_b), .MemSizeM(MemSizeM_b),
    .ALUControlE(ALUControlE_b), .ALUSrcAE(ALUSrcAE_b), .ALUSrcBE(ALUSrcBE_b),
    .WordOpE(WordOpE_b), .UwOpE(UwOpE_b), .BranchE(BranchE_b), .JumpE(JumpE_b),
    .JalrE(JalrE_b), .BranchFunctE(BranchFunctE_b), .IllegalW(IllegalW_b),
    .InstretW(InstretW_b)
  );

  // Observed outputs flattened: {D 4 bits, E 21 bits, M 7 bits, W 4 bits}.
  logic [35:0] obs_a, obs_b;
  assign obs_a = {ImmSrcD_a, IllegalD_a, RegWriteE_a, ResultSrcE_a, MemWriteE_a, MemSizeE_a,
                  ALUControlE_a, ALUSrcAE_a, ALUSrcBE_a, WordOpE_a, UwOpE_a, BranchE_a,
                  JumpE_a, JalrE_a, BranchFunctE_a, RegWriteM_a, ResultSrcM_a, MemWriteM_a,
                  MemSizeM_a, RegWriteW_a, ResultSrcW_a, IllegalW_a};
  assign obs_b = {ImmSrcD_b, IllegalD_b, RegWriteE_b, ResultSrcE_b, MemWriteE_b, MemSizeE_b,
                  ALUControlE_b, ALUSrcAE_b, ALUSrcBE_b, WordOpE_b, UwOpE_b, BranchE_b,
                  JumpE_b, JalrE_b, BranchFunctE_b, RegWriteM_b, ResultSrcM_b, MemWriteM_b,
                  MemSizeM_b, RegWriteW_b, ResultSrcW_b, IllegalW_b};

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] mem_size;
    logic [3:0] alu;
    logic       src_a;
    logic       src_b;
    logic       word;
    logic       uw;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] bfunct;
  } ctl_t;

  ctl_t        pe [2];
  ctl_t        pm [2];
  ctl_t        pw [2];
  logic [31:0] cnt [2];
  logic [31:0] cnt_mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  // funct3 -> ALU op for the base integer group; alt selects sub/sra.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd10, 4'd8, 4'd9, 4'd7, 4'd11, 4'd3, 4'd2};
    return tab[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
  endfunction

  function automatic logic [2:0] ref_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h6F:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic ctl_t ref_decode(input logic [31:0] ins, input bit rv64, input bit zba);
    ctl_t c;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    bit ok;
    bit shn;
    c = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    f6 = ins[31:26];
    ok = 0;
    shn = zba && (f7 == 7'h10) && (f3 inside {3'd2, 3'd4, 3'd6});
    case (ins[6:0])
      7'h03: begin
        ok = (f3 != 3'd7) && (rv64 || f3 != 3'd3);
        c.reg_write = 1; c.result_src = 2'b01; c.src_b = 1; c.mem_size = f3;
      end
      7'h23: begin
        ok = (f3 < 3'd4) && (rv64 || f3 != 3'd3);
        c.mem_write = 1; c.src_b = 1; c.mem_size = f3;
      end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f6 == 6'd0) : (f3 == 3'd5) ? (f6 == 6'd0 || f6 == 6'b010000) : 1'b1;
        c.reg_write = 1; c.src_b = 1; c.alu = alu_of(f3, f3 == 3'd5 && ins[30]);
      end
      7'h33: begin
        c.reg_write = 1;
        if (f7 == 7'h00) begin ok = 1; c.alu = alu_of(f3, 0); end
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ok = 1; c.alu = alu_of(f3, 1); end
        else if (shn) begin ok = 1; c.alu = 4'd3 + 4'(f3 >> 1); end
      end
      7'h3B: begin
        c.reg_write = 1;
        if (rv64 && f7 == 7'h00 && (f3 inside {3'd0, 3'd1, 3'd5})) begin
          ok = 1; c.word = 1; c.alu = alu_of(f3, 0);
        end else if (rv64 && f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          ok = 1; c.word = 1; c.alu = alu_of(f3, 1);
        end else if (rv64 && zba && f7 == 7'h04 && f3 == 3'd0) begin
          ok = 1; c.uw = 1; c.alu = 4'd0;
        end else if (rv64 && shn) begin
          ok = 1; c.uw = 1; c.alu = 4'd3 + 4'(f3 >> 1);
        end
      end
      7'h1B: begin
        ok = rv64 && ((f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                      (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
        c.reg_write = 1; c.src_b = 1; c.word = 1; c.alu = alu_of(f3, f3 == 3'd5 && ins[30]);
      end
      7'h63: begin
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        c.branch = 1; c.alu = 4'd1; c.bfunct = f3;
      end
      7'h6F: begin ok = 1; c.reg_write = 1; c.result_src = 2'b10; c.jump = 1; end
      7'h67: begin ok = 1; c.reg_write = 1; c.result_src = 2'b10; c.src_b = 1; c.jalr = 1; end
      7'h37: begin ok = 1; c.reg_write = 1; c.result_src = 2'b11; end
      7'h17: begin ok = 1; c.reg_write = 1; c.src_a = 1; c.src_b = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      c = '0;
      c.illegal = 1;
    end else begin
      c.valid = 1;
    end
    return c;
  endfunction

  function automatic logic [35:0] pack_exp(input ctl_t d, input ctl_t e, input ctl_t m,
                                           input ctl_t w, input logic [2:0] imm);
    return {imm, d.illegal, e.reg_write, e.result_src, e.mem_write, e.mem_size, e.alu,
            e.src_a, e.src_b, e.word, e.uw, e.branch, e.jump, e.jalr, e.bfunct,
            m.reg_write, m.result_src, m.mem_write, m.mem_size,
            w.reg_write, w.result_src, w.illegal};
  endfunction

  // One clock edge: advance the model with the inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pe[k] = '0; pm[k] = '0; pw[k] = '0; cnt[k] = '0;
      end else begin
        if (pw[k].valid && !pw[k].illegal) cnt[k] = (cnt[k] + 1) & cnt_mask[k];
        pw[k] = pm[k];
        pm[k] = pe[k];
        pe[k] = FlushE ? '0 : ref_decode(InstrD, k == 0, k == 0);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; FlushE = 0; InstrD = 32'h0;
    tick();
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    $display("[TB] reset applied");
    tests_run++;
    if (obs_a[31:0] !== 32'h0 || InstretW_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_a: got emw=%08h cnt=%0d expected 0", obs_a[31:0], InstretW_a);
    end
    tests_run++;
    if (obs_b[31:0] !== 32'h0 || InstretW_b !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_b: got emw=%08h cnt=%0d expected 0", obs_b[31:0], InstretW_b);
    end
  endtask

  task automatic test_arith();
    logic [31:0] prog [3];
    logic [3:0]  alu_exp [3];
    prog = '{32'h002081B3, 32'h402081B3, 32'h2020A1B3};
    alu_exp = '{4'd0, 4'd1, 4'd4};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      InstrD = prog[i];
      tick();
      $display("[TB] arith instr=%08h", prog[i]);
      tests_run++;
      if (ALUControlE_a !== alu_exp[i]) begin
        tests_failed++;
        $display("FAIL arith_alu%0d: got %b expected %b", i, ALUControlE_a, alu_exp[i]);
      end
    end
    FlushE = 1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (RegWriteW_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL arith_regwritew%0d: got %b expected 1", i, RegWriteW_a);
      end
      tick();
    end
    tests_run++;
    if (InstretW_a !== 32'd3 || InstretW_b !== 4'd2) begin
      tests_failed++;
      $display("FAIL arith_instret: got a=%0d b=%0d expected a=3 b=2", InstretW_a, InstretW_b);
    end
  endtask

  task automatic test_load();
    do_reset();
    InstrD = 32'h0000B283;
    #1;
    $display("[TB] load instr=%08h", InstrD);
    tests_run++;
    if (ImmSrcD_a !== 3'b000 || IllegalD_a !== 1'b0 || IllegalD_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_d: got imm=%b illa=%b illb=%b expected 000 0 1", ImmSrcD_a, IllegalD_a, IllegalD_b);
    end
    tick();
    FlushE = 1;
    tests_run++;
    if (ALUSrcBE_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_srcb: got %b expected 1", ALUSrcBE_a);
    end
    tick();
    tests_run++;
    if (ResultSrcM_a !== 2'b01 || MemSizeM_a !== 3'b011) begin
      tests_failed++;
      $display("FAIL load_m: got res=%b size=%b expected 01 011", ResultSrcM_a, MemSizeM_a);
    end
    tick();
    tests_run++;
    if (IllegalW_b !== 1'b1 || RegWriteW_b !== 1'b0 || RegWriteW_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_w: got illb=%b rwb=%b rwa=%b expected 1 0 1", IllegalW_b, RegWriteW_b, RegWriteW_a);
    end
    tick();
    tick();
    tests_run++;
    if (InstretW_b !== 4'd0 || InstretW_a !== 32'd1) begin
      tests_failed++;
      $display("FAIL load_instret: got a=%0d b=%0d expected a=1 b=0", InstretW_a, InstretW_b);
    end
  endtask

  task automatic test_zba_addw();
    do_reset();
    InstrD = 32'h2020A1B3;
    #1;
    $display("[TB] zba instr=%08h", InstrD);
    tests_run++;
    if (IllegalD_b !== 1'b1 || IllegalD_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL zba_illegal: got a=%b b=%b expected a=0 b=1", IllegalD_a, IllegalD_b);
    end
    tick();
    tests_run++;
    if (obs_b[31:11] !== 21'h0 || ALUControlE_a !== 4'd4) begin
      tests_failed++;
      $display("FAIL zba_bundle: got ebundle_b=%06h alu_a=%b expected 0 0100", obs_b[31:11], ALUControlE_a);
    end
    InstrD = 32'h002081BB;
    #1;
    $display("[TB] addw instr=%08h", InstrD);
    tests_run++;
    if (IllegalD_b !== 1'b1 || IllegalD_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL addw_illegal: got a=%b b=%b expected a=0 b=1", IllegalD_a, IllegalD_b);
    end
    tick();
    tests_run++;
    if (WordOpE_a !== 1'b1 || ALUControlE_a !== 4'd0 || UwOpE_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL addw_e: got word=%b alu=%b uw=%b expected 1 0000 0", WordOpE_a, ALUControlE_a, UwOpE_a);
    end
  endtask

  task automatic test_flush();
    do_reset();
    InstrD = 32'h000000EF;
    FlushE = 1;
    tick();
    $display("[TB] flush jal instr=%08h", InstrD);
    tests_run++;
    if (JumpE_a !== 1'b0 || RegWriteE_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_e: got jump=%b rw=%b expected 0 0", JumpE_a, RegWriteE_a);
    end
    FlushE = 0;
    tick();
    tests_run++;
    if (JumpE_a !== 1'b1 || RegWriteE_a !== 1'b1 || ResultSrcE_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL noflush_e: got jump=%b rw=%b res=%b expected 1 1 10", JumpE_a, RegWriteE_a, ResultSrcE_a);
    end
    FlushE = 1;
    tick();
    tick();
    tick();
    tests_run++;
    if (InstretW_a !== 32'd1) begin
      tests_failed++;
      $display("FAIL flush_instret: got %0d expected 1", InstretW_a);
    end
  endtask

  task automatic test_lui_reset();
    do_reset();
    InstrD = 32'h123452B7;
    #1;
    $display("[TB] lui instr=%08h", InstrD);
    tests_run++;
    if (ImmSrcD_a !== 3'b100) begin
      tests_failed++;
      $display("FAIL lui_imm: got %b expected 100", ImmSrcD_a);
    end
    tick();
    FlushE = 1;
    tick();
    tick();
    tests_run++;
    if (ResultSrcW_a !== 2'b11 || RegWriteW_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL lui_w: got res=%b rw=%b expected 11 1", ResultSrcW_a, RegWriteW_a);
    end
    // Second lui is caught in M by a reset.
    FlushE = 0;
    tick();
    FlushE = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    tests_run++;
    if (RegWriteW_a !== 1'b0 || InstretW_a !== 32'd0 || obs_a[31:0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL lui_reset: got rw=%b cnt=%0d emw=%08h expected 0 0 0", RegWriteW_a, InstretW_a, obs_a[31:0]);
    end
    tick();
    tick();
    tests_run++;
    if (RegWriteW_a !== 1'b0 || InstretW_a !== 32'd0) begin
      tests_failed++;
      $display("FAIL lui_drop: got rw=%b cnt=%0d expected 0 0", RegWriteW_a, InstretW_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    InstrD = 32'h002081B3;
    for (int i = 0; i < 16; i++) tick();
    FlushE = 1;
    tick();
    tick();
    $display("[TB] wrap after 15 retires");
    tests_run++;
    if (InstretW_b !== 4'd15) begin
      tests_failed++;
      $display("FAIL wrap_pre: got %0d expected 15", InstretW_b);
    end
    tick();
    tests_run++;
    if (InstretW_b !== 4'd0 || InstretW_a !== 32'd16) begin
      tests_failed++;
      $display("FAIL wrap: got b=%0d a=%0d expected b=0 a=16", InstretW_b, InstretW_a);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    logic [6:0] f7s [4];
    logic [35:0] exp_a, exp_b;
    ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    f7s = '{7'h00, 7'h20, 7'h10, 7'h04};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      InstrD = $urandom;
      if ($urandom_range(3) != 0) begin
        InstrD[6:0] = ops[$urandom_range(10)];
        if ($urandom_range(1) == 1) InstrD[31:25] = f7s[$urandom_range(3)];
      end
      FlushE = ($urandom_range(7) == 0);
      reset  = ($urandom_range(63) == 0);
      #1;
      $display("[TB] rand %0d instr=%08h flush=%0b reset=%0b", i, InstrD, FlushE, reset);
      exp_a = pack_exp(ref_decode(InstrD, 1, 1), pe[0], pm[0], pw[0], ref_imm(InstrD));
      exp_b = pack_exp(ref_decode(InstrD, 0, 0), pe[1], pm[1], pw[1], ref_imm(InstrD));
      tests_run++;
      if (obs_a !== exp_a || InstretW_a !== cnt[0]) begin
        tests_failed++;
        $display("FAIL rand_a %0d: got %09h cnt=%0d expected %09h cnt=%0d", i, obs_a, InstretW_a, exp_a, cnt[0]);
      end
      tests_run++;
      if (obs_b !== exp_b || InstretW_b !== cnt[1][3:0]) begin
        tests_failed++;
        $display("FAIL rand_b %0d: got %09h cnt=%0d expected %09h cnt=%0d", i, obs_b, InstretW_b, exp_b, cnt[1][3:0]);
      end
      tick();
    end
    reset = 0;
    FlushE = 0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_load();
    test_zba_addw();
    test_flush();
    test_lui_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
